// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-client arbiter (I-cache, D-cache) onto one shared block-wide memory
//   port. Only one transaction is outstanding; the address, write data and
//   direction are registered at grant and held stable until mem_ready.
//
// Ports:
//   clk, proc_reset_n        system clock (rising edge), async active-low reset
//   i_read, i_addr           I-cache block read request, held until i_ready
//   i_rdata, i_ready         I-cache read data (ungated), one-cycle completion
//   d_read, d_write          D-cache allocate / writeback requests
//   d_addr, d_wdata          D-cache block address and writeback data
//   d_rdata, d_ready         D-cache read data (ungated), one-cycle completion
//   mem_read, mem_write      registered memory strobes
//   mem_addr, mem_wdata      registered memory address / write data
//   mem_rdata, mem_ready     memory read data and completion
module mem_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t r_state;
    logic   r_last_d;   // 1 = D was granted last, 0 = I

    logic w_i_req;
    logic w_d_req;
    logic w_grant_d;
    logic w_grant_i;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    // D wins on contention unless round-robin is on and D was served last.
    assign w_grant_d = w_d_req && (!w_i_req || !RR_EN || !r_last_d);
    assign w_grant_i = w_i_req && !w_grant_d;

    // Completion is combinational with mem_ready and gated by ownership,
    // so mem_ready while IDLE never reaches a client.
    assign i_ready = (r_state == BUSY_I) && mem_ready;
    assign d_ready = (r_state == BUSY_D) && mem_ready;

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state   <= IDLE;
            r_last_d  <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= BUSY_D;
                        r_last_d  <= 1'b1;
                        mem_addr  <= d_addr;
                        // A writeback takes precedence if both strobes are up.
                        mem_write <= d_write;
                        mem_read  <= !d_write;
                        if (d_write) begin
                            mem_wdata <= d_wdata;
                        end
                    end else if (w_grant_i) begin
                        r_state   <= BUSY_I;
                        r_last_d  <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_read  <= 1'b1;
                        mem_write <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Runs to completion even if the owner drops its request.
                    if (mem_ready) begin
                        r_state   <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    typedef struct {
        logic         cli;    // 1 = D, 0 = I
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } exp_t;

    typedef struct {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        int           cyc;
    } obs_t;

    typedef struct {
        logic         cli;
        logic [127:0] rdata;
        int           cyc;
    } rdy_t;

    logic         clk;
    logic         proc_reset_n;
    logic         i_read, d_read, d_write;
    logic [27:0]  i_addr, d_addr;
    logic [127:0] d_wdata;
    logic [127:0] i_rdata, d_rdata;
    logic         i_ready, d_ready;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;

    logic         fp_i_read, fp_d_read, fp_d_write;
    logic [27:0]  fp_i_addr, fp_d_addr;
    logic [127:0] fp_d_wdata, fp_i_rdata, fp_d_rdata;
    logic         fp_i_ready, fp_d_ready;
    logic         fp_mem_read, fp_mem_write;
    logic [27:0]  fp_mem_addr;
    logic [127:0] fp_mem_wdata, fp_mem_rdata;
    logic         fp_mem_ready;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   lat = 4;
    int   cnt = 0;
    int   hold_viol = 0;
    int   both_viol = 0;
    logic mem_auto = 1'b1;
    logic model_rdy = 1'b0;
    logic man_rdy = 1'b0;
    logic use_a5 = 1'b0;
    logic prev_s = 1'b0;
    logic [157:0] prev_bus = '0;
    logic [127:0] model_wd = '0;

    exp_t exp_q[$];
    obs_t obs_q[$];
    rdy_t rdy_q[$];

    mem_arbiter #(.ADDR_W(28), .DATA_W(128), .RR_EN(1'b1)) u_dut (
        .clk(clk), .proc_reset_n(proc_reset_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_arbiter #(.ADDR_W(28), .DATA_W(128), .RR_EN(1'b0)) u_fp (
        .clk(clk), .proc_reset_n(proc_reset_n),
        .i_read(fp_i_read), .i_addr(fp_i_addr), .i_rdata(fp_i_rdata), .i_ready(fp_i_ready),
        .d_read(fp_d_read), .d_write(fp_d_write), .d_addr(fp_d_addr), .d_wdata(fp_d_wdata),
        .d_rdata(fp_d_rdata), .d_ready(fp_d_ready),
        .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_addr(fp_mem_addr),
        .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata), .mem_ready(fp_mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: mem_ready pulses 'lat' cycles after a strobe rises.
    assign mem_ready    = model_rdy | man_rdy;
    assign mem_rdata    = use_a5 ? {16{8'hA5}} : {4{4'hC, mem_addr}};
    assign fp_mem_ready = fp_mem_read | fp_mem_write;
    assign fp_mem_rdata = '0;

    always @(posedge clk) begin
        if (model_rdy) begin
            model_rdy <= 1'b0;
        end else if (mem_auto && (mem_read || mem_write)) begin
            if (cnt >= lat - 1) begin
                model_rdy <= 1'b1;
                cnt       <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    // Monitor: records issued transactions and ready pulses.
    always @(negedge clk) begin
        if ((mem_read || mem_write) && !prev_s)
            obs_q.push_back(obs_t'{mem_write, mem_addr, mem_wdata, cyc});
        if ((mem_read || mem_write) && prev_s && ({mem_write, mem_read, mem_addr, mem_wdata} != prev_bus))
            hold_viol <= hold_viol + 1;
        if (i_ready) rdy_q.push_back(rdy_t'{1'b0, i_rdata, cyc});
        if (d_ready) rdy_q.push_back(rdy_t'{1'b1, d_rdata, cyc});
        if (i_ready && d_ready) both_viol <= both_viol + 1;
        prev_s   <= mem_read | mem_write;
        prev_bus <= {mem_write, mem_read, mem_addr, mem_wdata};
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got time=%0t want <300000", $time);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic cli, input logic wr, input logic [27:0] addr, input logic [127:0] wd);
        exp_t e;
        if (wr) model_wd = wd;
        e.cli   = cli;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = model_wd;
        e.rdata = use_a5 ? {16{8'hA5}} : {4{4'hC, addr}};
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input logic cli, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (cli ? d_ready : i_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        proc_reset_n = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        model_wd = '0;
        tick(2);
        proc_reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        proc_reset_n = 1'b0;
        man_rdy = 1'b1;
        #12;
        checks++;
        if ({mem_read, mem_write, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mem got rd=%0b wr=%0b a=%h wd=%h want all 0", mem_read, mem_write, mem_addr, mem_wdata);
        end
        checks++;
        if ({i_ready, d_ready, fp_i_ready, fp_d_ready} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ready got i=%0b d=%0b fpi=%0b fpd=%0b want 0", i_ready, d_ready, fp_i_ready, fp_d_ready);
        end
        man_rdy = 1'b0;
        @(posedge clk);
        #1;
        proc_reset_n = 1'b1;
        tick(4);
        checks++;
        if ({mem_read, mem_write} !== 2'b00 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL idle_no_req got rd=%0b wr=%0b issued=%0d want 0 0 0", mem_read, mem_write, obs_q.size());
        end
    endtask

    task automatic test_d_read();
        int   t_rise, t_rdy, i_bad, r_bad;
        bit   seen;
        logic [127:0] cap;
        exp_t e; obs_t o; rdy_t r;
        use_a5 = 1'b1; lat = 4; mem_auto = 1'b1;
        exp_push(1'b1, 1'b0, 28'h0000123, '0);
        d_read = 1'b1; d_addr = 28'h0000123;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0) begin
            errors++;
            $display("FAIL dread_early got mem_read=%0b want 0", mem_read);
        end
        @(negedge clk);
        checks++;
        if ({mem_read, mem_write, mem_addr} !== {1'b1, 1'b0, 28'h0000123}) begin
            errors++;
            $display("FAIL dread_issue got rd=%0b wr=%0b a=%h want 1 0 0000123", mem_read, mem_write, mem_addr);
        end
        t_rise = cyc; t_rdy = 0; seen = 1'b0; i_bad = 0; r_bad = 0; cap = '0;
        for (int n = 0; n < 60; n++) begin
            if (i_ready !== 1'b0) i_bad++;
            if (d_ready !== mem_ready) r_bad++;
            if (d_ready) begin
                seen = 1'b1; t_rdy = cyc; cap = d_rdata;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen || (t_rdy - t_rise) != 4) begin
            errors++;
            $display("FAIL dread_latency got seen=%0b cycles=%0d want 1 4", seen, t_rdy - t_rise);
        end
        checks++;
        if (cap !== {16{8'hA5}}) begin
            errors++;
            $display("FAIL dread_rdata got %h want %h", cap, {16{8'hA5}});
        end
        @(posedge clk);
        #1;
        d_read = 1'b0;
        @(negedge clk);
        if (i_ready !== 1'b0) i_bad++;
        checks++;
        if ({mem_read, d_ready} !== 2'b00 || i_bad != 0 || r_bad != 0) begin
            errors++;
            $display("FAIL dread_after got rd=%0b d_ready=%0b i_bad=%0d ready_mismatch=%0d want 0 0 0 0", mem_read, d_ready, i_bad, r_bad);
        end
        use_a5 = 1'b0;
        checks++;
        if (obs_q.size() != exp_q.size() || rdy_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL dread_count got tx=%0d rdy=%0d want %0d", obs_q.size(), rdy_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0 && rdy_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); r = rdy_q.pop_front();
            checks++;
            if ({o.wr, o.addr, o.wdata, r.cli, r.rdata} !== {e.wr, e.addr, e.wdata, e.cli, e.rdata}) begin
                errors++;
                $display("FAIL dread_tx got wr=%0b a=%h wd=%h c=%0b rd=%h want wr=%0b a=%h wd=%h c=%0b rd=%h",
                         o.wr, o.addr, o.wdata, r.cli, r.rdata, e.wr, e.addr, e.wdata, e.cli, e.rdata);
            end
        end
        exp_q.delete(); obs_q.delete(); rdy_q.delete();
    endtask

    task automatic test_d_write();
        bit   ok;
        exp_t e; obs_t o; rdy_t r;
        lat = 5;
        exp_push(1'b1, 1'b1, 28'h00000AB, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        d_write = 1'b1; d_addr = 28'h00000AB;
        d_wdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        tick(3);
        // Inputs change after grant; the issued request must not follow them.
        d_addr = 28'hFFFFFFF; d_wdata = ~d_wdata;
        wait_ready(1'b1, ok);
        d_write = 1'b0;
        tick(3);
        checks++;
        if (!ok || hold_viol != 0) begin
            errors++;
            $display("FAIL dwrite_hold got ready_seen=%0b hold_viol=%0d want 1 0", ok, hold_viol);
        end
        checks++;
        if (obs_q.size() != exp_q.size() || rdy_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL dwrite_count got tx=%0d rdy=%0d want %0d", obs_q.size(), rdy_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0 && rdy_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); r = rdy_q.pop_front();
            checks++;
            if ({o.wr, o.addr, o.wdata, r.cli, r.rdata} !== {e.wr, e.addr, e.wdata, e.cli, e.rdata}) begin
                errors++;
                $display("FAIL dwrite_tx got wr=%0b a=%h wd=%h c=%0b rd=%h want wr=%0b a=%h wd=%h c=%0b rd=%h",
                         o.wr, o.addr, o.wdata, r.cli, r.rdata, e.wr, e.addr, e.wdata, e.cli, e.rdata);
            end
        end
        exp_q.delete(); obs_q.delete(); rdy_q.delete();
    endtask

    task automatic test_round_robin();
        bit   ok_d[2], ok_i[2];
        exp_t e; obs_t o; rdy_t r;
        do_reset();
        lat = 2;
        exp_push(1'b1, 1'b0, 28'h0000300, '0);
        exp_push(1'b0, 1'b0, 28'h0000200, '0);
        exp_push(1'b1, 1'b0, 28'h0000301, '0);
        exp_push(1'b0, 1'b0, 28'h0000201, '0);
        fork
            begin
                for (int k = 0; k < 2; k++) begin
                    d_read = 1'b1; d_addr = 28'h0000300 | 28'(k);
                    wait_ready(1'b1, ok_d[k]);
                end
                d_read = 1'b0;
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    i_read = 1'b1; i_addr = 28'h0000200 | 28'(k);
                    wait_ready(1'b0, ok_i[k]);
                end
                i_read = 1'b0;
            end
        join
        tick(2);
        checks++;
        if (!(ok_d[0] && ok_d[1] && ok_i[0] && ok_i[1]) || both_viol != 0) begin
            errors++;
            $display("FAIL rr_done got d=%0b%0b i=%0b%0b both_ready=%0d want 11 11 0", ok_d[0], ok_d[1], ok_i[0], ok_i[1], both_viol);
        end
        checks++;
        if (obs_q.size() != exp_q.size() || rdy_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rr_count got tx=%0d rdy=%0d want %0d", obs_q.size(), rdy_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0 && rdy_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); r = rdy_q.pop_front();
            checks++;
            if ({o.wr, o.addr, o.wdata, r.cli, r.rdata} !== {e.wr, e.addr, e.wdata, e.cli, e.rdata}) begin
                errors++;
                $display("FAIL rr_tx got wr=%0b a=%h wd=%h c=%0b rd=%h want wr=%0b a=%h wd=%h c=%0b rd=%h",
                         o.wr, o.addr, o.wdata, r.cli, r.rdata, e.wr, e.addr, e.wdata, e.cli, e.rdata);
            end
        end
        exp_q.delete(); obs_q.delete(); rdy_q.delete();
    endtask

    task automatic test_fixed_priority();
        int d_cnt, i_cnt, a_bad;
        fp_d_read = 1'b1; fp_d_addr = 28'h0000D00;
        fp_i_read = 1'b1; fp_i_addr = 28'h0000100;
        d_cnt = 0; i_cnt = 0; a_bad = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (fp_d_ready) begin
                d_cnt++;
                if (fp_mem_addr !== 28'h0000D00) a_bad++;
            end
            if (fp_i_ready) i_cnt++;
        end
        checks++;
        if (d_cnt != 4 || i_cnt != 0 || a_bad != 0) begin
            errors++;
            $display("FAIL fixed_d_wins got d=%0d i=%0d addr_bad=%0d want 4 0 0", d_cnt, i_cnt, a_bad);
        end
        @(posedge clk);
        #1;
        fp_d_read = 1'b0;
        d_cnt = 0; i_cnt = 0; a_bad = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (fp_d_ready) d_cnt++;
            if (fp_i_ready) begin
                i_cnt++;
                if (fp_mem_addr !== 28'h0000100) a_bad++;
            end
        end
        fp_i_read = 1'b0;
        checks++;
        if (d_cnt != 0 || i_cnt != 1 || a_bad != 0) begin
            errors++;
            $display("FAIL fixed_i_after got d=%0d i=%0d addr_bad=%0d want 0 1 0", d_cnt, i_cnt, a_bad);
        end
    endtask

    task automatic test_wb_alloc();
        bit   ok0, ok1, ok2;
        int   gap_bad;
        exp_t e; obs_t o; rdy_t r;
        do_reset();
        lat = 3;
        exp_push(1'b1, 1'b1, 28'h0000010, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0);
        exp_push(1'b0, 1'b0, 28'h0000400, '0);
        exp_push(1'b1, 1'b0, 28'h0000050, '0);
        fork
            begin
                d_write = 1'b1; d_addr = 28'h0000010;
                d_wdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
                wait_ready(1'b1, ok0);
                d_write = 1'b0; d_read = 1'b1; d_addr = 28'h0000050;
                wait_ready(1'b1, ok1);
                d_read = 1'b0;
            end
            begin
                i_read = 1'b1; i_addr = 28'h0000400;
                wait_ready(1'b0, ok2);
                i_read = 1'b0;
            end
        join
        tick(2);
        gap_bad = 0;
        for (int k = 1; k < obs_q.size() && k <= rdy_q.size(); k++)
            if (obs_q[k].cyc - rdy_q[k-1].cyc < 2) gap_bad++;
        checks++;
        if (!(ok0 && ok1 && ok2) || gap_bad != 0 || hold_viol != 0) begin
            errors++;
            $display("FAIL wb_gap got done=%0b%0b%0b short_gaps=%0d hold_viol=%0d want 111 0 0", ok0, ok1, ok2, gap_bad, hold_viol);
        end
        checks++;
        if (obs_q.size() != exp_q.size() || rdy_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL wb_count got tx=%0d rdy=%0d want %0d", obs_q.size(), rdy_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0 && rdy_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); r = rdy_q.pop_front();
            checks++;
            if ({o.wr, o.addr, o.wdata, r.cli, r.rdata} !== {e.wr, e.addr, e.wdata, e.cli, e.rdata}) begin
                errors++;
                $display("FAIL wb_tx got wr=%0b a=%h wd=%h c=%0b rd=%h want wr=%0b a=%h wd=%h c=%0b rd=%h",
                         o.wr, o.addr, o.wdata, r.cli, r.rdata, e.wr, e.addr, e.wdata, e.cli, e.rdata);
            end
        end
        exp_q.delete(); obs_q.delete(); rdy_q.delete();
    endtask

    task automatic test_reset_busy();
        int bad;
        lat = 20; mem_auto = 1'b1;
        d_read = 1'b1; d_addr = 28'h0000077;
        tick(3);
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL rstbusy_pre got mem_read=%0b want 1", mem_read);
        end
        #2;
        proc_reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, d_ready, i_ready} !== 4'b0) begin
            errors++;
            $display("FAIL rstbusy_async got rd=%0b wr=%0b d_ready=%0b i_ready=%0b want 0", mem_read, mem_write, d_ready, i_ready);
        end
        d_read = 1'b0;
        model_wd = '0;
        @(posedge clk);
        #1;
        proc_reset_n = 1'b1;
        tick(1);
        mem_auto = 1'b0;
        man_rdy = 1'b1;
        bad = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if ({i_ready, d_ready, mem_read, mem_write} !== 4'b0) bad++;
        end
        @(posedge clk);
        #1;
        man_rdy = 1'b0;
        mem_auto = 1'b1;
        checks++;
        if (bad != 0 || rdy_q.size() != 0 || obs_q.size() != 1) begin
            errors++;
            $display("FAIL rstbusy_idle_ready got bad_cycles=%0d pulses=%0d issued=%0d want 0 0 1", bad, rdy_q.size(), obs_q.size());
        end
        exp_q.delete(); obs_q.delete(); rdy_q.delete();
    endtask

    task automatic test_abandon();
        int   pulses, early, done;
        logic after_rd;
        bit   ok;
        exp_t e; obs_t o; rdy_t r;
        lat = 6;
        exp_push(1'b1, 1'b0, 28'h0000066, '0);
        d_read = 1'b1; d_addr = 28'h0000066;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL abandon_issue got mem_read=%0b want 1", mem_read);
        end
        @(posedge clk);
        #1;
        tick(1);
        d_read = 1'b0;
        pulses = 0; early = 0; done = -1; after_rd = 1'bx;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done < 0) begin
                if (mem_read !== 1'b1) early++;
                if (d_ready) begin
                    pulses++;
                    done = n;
                end
            end else begin
                if (d_ready) pulses++;
                if (n == done + 1) after_rd = mem_read;
                if (n == done + 3) break;
            end
        end
        checks++;
        if (done < 0 || early != 0 || pulses != 1 || after_rd !== 1'b0) begin
            errors++;
            $display("FAIL abandon_run got done=%0d early_drop=%0d pulses=%0d rd_after=%0b want >=0 0 1 0", done, early, pulses, after_rd);
        end
        @(posedge clk);
        #1;
        exp_push(1'b0, 1'b0, 28'h0000099, '0);
        i_read = 1'b1; i_addr = 28'h0000099;
        wait_ready(1'b0, ok);
        i_read = 1'b0;
        tick(2);
        checks++;
        if (!ok || obs_q.size() != exp_q.size() || rdy_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL abandon_count got next_done=%0b tx=%0d rdy=%0d want 1 %0d", ok, obs_q.size(), rdy_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0 && rdy_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); r = rdy_q.pop_front();
            checks++;
            if ({o.wr, o.addr, o.wdata, r.cli, r.rdata} !== {e.wr, e.addr, e.wdata, e.cli, e.rdata}) begin
                errors++;
                $display("FAIL abandon_tx got wr=%0b a=%h wd=%h c=%0b rd=%h want wr=%0b a=%h wd=%h c=%0b rd=%h",
                         o.wr, o.addr, o.wdata, r.cli, r.rdata, e.wr, e.addr, e.wdata, e.cli, e.rdata);
            end
        end
        exp_q.delete(); obs_q.delete(); rdy_q.delete();
    endtask

    initial begin
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        fp_i_read = 1'b0; fp_d_read = 1'b0; fp_d_write = 1'b0;
        fp_i_addr = '0; fp_d_addr = '0; fp_d_wdata = '0;
        test_reset();
        test_d_read();
        test_d_write();
        test_round_robin();
        test_fixed_priority();
        test_wb_alloc();
        test_reset_busy();
        test_abandon();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
